// File: rtl/pipelined_byte_mask_sram_if.sv
// Request/response bus for pipelined_byte_mask_sram: byte-masked request channel
// plus a valid/ready response channel.
interface pipelined_byte_mask_sram_if #(
   parameter int DATAW = 32,
   parameter int ADDRW = 7
);
   logic [DATAW-1:0]   adata;
   logic [ADDRW-1:0]   aaddr;
   logic               avalid;
   logic               awren;
   logic [DATAW/8-1:0] astrb;
   logic               aready;
   logic               rvalid;
   logic               rready;
   logic [DATAW-1:0]   rdata;

   modport master (
      output adata, aaddr, avalid, awren, astrb, rready,
      input  aready, rvalid, rdata
   );

   modport slave (
      input  adata, aaddr, avalid, awren, astrb, rready,
      output aready, rvalid, rdata
   );
endinterface

// File: rtl/pipelined_byte_mask_sram.sv
// Byte-masked single-port SRAM with a fixed-latency read pipeline feeding a credit-limited response queue.
// Optional macro SRAM_WRITE_RESP_EN: when defined, accepted writes also return the merged word as a response.
module pipelined_byte_mask_sram #(
   parameter int DATAW      = 32,
   parameter int ADDRW      = 7,
   parameter int RD_LATENCY = 2,
   parameter int OUTQ_DEPTH = RD_LATENCY + 1
) (
   input logic                      clk,
   input logic                      rstx,
   pipelined_byte_mask_sram_if.slave bus
);
   localparam int STRBW = DATAW / 8;
   localparam int DEPTH = 1 << ADDRW;
   localparam int QPW   = (OUTQ_DEPTH > 1) ? $clog2(OUTQ_DEPTH) : 1;
   localparam int CNTW  = $clog2(OUTQ_DEPTH + 1);

   logic [DATAW-1:0] mem   [DEPTH];
   logic [DATAW-1:0] q_mem [OUTQ_DEPTH];

   logic [CNTW-1:0]  outstanding;
   logic [CNTW-1:0]  q_count;
   logic [QPW-1:0]   wr_ptr;
   logic [QPW-1:0]   rd_ptr;

   logic             accept;
   logic             resp_gen;
   logic             pop;
   logic             rvalid_int;
   logic             q_in_valid;
   logic [DATAW-1:0] q_in_data;
   logic [DATAW-1:0] cur_word;
   logic [DATAW-1:0] merged;
   logic [DATAW-1:0] cap_data;

   function automatic logic [QPW-1:0] ptr_next(input logic [QPW-1:0] p);
      return (p == QPW'(OUTQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credits cover both pipeline and queue, so the queue can never overflow.
   assign bus.aready = (outstanding < CNTW'(OUTQ_DEPTH));
   assign accept     = bus.avalid && bus.aready;
   assign rvalid_int = (q_count != '0);
   assign pop        = rvalid_int && bus.rready;

`ifdef SRAM_WRITE_RESP_EN
   assign resp_gen = accept;
`else
   assign resp_gen = accept && !bus.awren;
`endif

   assign cur_word = mem[bus.aaddr];

   always_comb begin
      merged = cur_word;
      for (int i = 0; i < STRBW; i++) begin
         if (bus.astrb[i]) begin
            merged[8*i +: 8] = bus.adata[8*i +: 8];
         end
      end
   end

   assign cap_data = bus.awren ? merged : cur_word;

   // The array is deliberately never reset so stored data survives a reset.
   always_ff @(posedge clk) begin
      if (accept && bus.awren) begin
         mem[bus.aaddr] <= merged;
      end
   end

   generate
      if (RD_LATENCY > 1) begin : g_pipe
         logic [RD_LATENCY-2:0] pipe_valid;
         logic [DATAW-1:0]      pipe_data [RD_LATENCY-1];

         always_ff @(posedge clk or negedge rstx) begin
            if (!rstx) begin
               pipe_valid <= '0;
            end else begin
               pipe_valid[0] <= resp_gen;
               for (int i = 1; i < RD_LATENCY - 1; i++) begin
                  pipe_valid[i] <= pipe_valid[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            pipe_data[0] <= cap_data;
            for (int i = 1; i < RD_LATENCY - 1; i++) begin
               pipe_data[i] <= pipe_data[i-1];
            end
         end

         assign q_in_valid = pipe_valid[RD_LATENCY-2];
         assign q_in_data  = pipe_data[RD_LATENCY-2];
      end else begin : g_nopipe
         assign q_in_valid = resp_gen;
         assign q_in_data  = cap_data;
      end
   endgenerate

   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         outstanding <= '0;
         q_count     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         case ({resp_gen, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         case ({q_in_valid, pop})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: q_count <= q_count;
         endcase
         if (q_in_valid) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (q_in_valid) begin
         q_mem[wr_ptr] <= q_in_data;
      end
   end

   // Gating keeps rdata at zero whenever nothing is being presented.
   assign bus.rvalid = rvalid_int;
   assign bus.rdata  = rvalid_int ? q_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_pipelined_byte_mask_sram.sv
// Directed, scoreboard-based testbench for pipelined_byte_mask_sram (default parameters).
// Follows SRAM_WRITE_RESP_EN the same way the design does.
module tb_pipelined_byte_mask_sram;
   localparam int DATAW = 32;
   localparam int ADDRW = 7;
   localparam int LAT   = 2;
   localparam int QDEP  = LAT + 1;
`ifdef SRAM_WRITE_RESP_EN
   localparam bit WR_RESP = 1'b1;
`else
   localparam bit WR_RESP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstx;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   resp_count = 0;
   int   first_cyc = 0;
   int   last_cyc = 0;
   logic hold = 1'b0;
   logic [DATAW-1:0] held_data = '0;
   logic [DATAW-1:0] model [1 << ADDRW];
   logic [DATAW-1:0] sb [$];

   pipelined_byte_mask_sram_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

   pipelined_byte_mask_sram #(
      .DATAW(DATAW), .ADDRW(ADDRW), .RD_LATENCY(LAT), .OUTQ_DEPTH(QDEP)
   ) dut (
      .clk (clk),
      .rstx(rstx),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard and checks stability under backpressure.
   always @(negedge clk) begin
      if (!rstx) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("stall_rvalid", {31'd0, bus.rvalid}, 32'd1);
            check("stall_rdata", bus.rdata, held_data);
         end
         if (bus.rvalid && bus.rready) begin
            total++;
            assert (sb.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_resp observed=%h expected=no_response", bus.rdata);
            end
            if (sb.size() != 0) begin
               check("resp_data", bus.rdata, sb.pop_front());
            end
            if (resp_count == 0) first_cyc = cyc;
            last_cyc = cyc;
            resp_count++;
         end
         hold      = bus.rvalid && !bus.rready;
         held_data = bus.rdata;
      end
   end

   task automatic issue(input logic wr, input logic [ADDRW-1:0] addr,
                        input logic [DATAW-1:0] data, input logic [3:0] strb);
      int guard;
      logic [DATAW-1:0] word;
      guard      = 0;
      bus.avalid = 1'b1;
      bus.awren  = wr;
      bus.aaddr  = addr;
      bus.adata  = data;
      bus.astrb  = strb;
      while (!bus.aready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      total++;
      assert (guard < 50) else begin
         bad++;
         $error("FAIL accept_timeout observed=%0d expected=<50", guard);
      end
      word = model[addr];
      if (wr) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
         end
         model[addr] = word;
      end
      if (!wr || WR_RESP) sb.push_back(word);
      @(posedge clk);
      #1;
      bus.avalid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || bus.rvalid) && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      total++;
      assert (guard < 200) else begin
         bad++;
         $error("FAIL drain_timeout observed=%0d expected=<200", guard);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int accepted;
      int t0;
      int exp_resp;

      rstx       = 1'b0;
      bus.avalid = 1'b0;
      bus.awren  = 1'b0;
      bus.aaddr  = '0;
      bus.adata  = '0;
      bus.astrb  = '0;
      bus.rready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
      check("reset_rdata", bus.rdata, 32'd0);
      rstx = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_aready", {31'd0, bus.aready}, 32'd1);

      // Full write then read; response appears in the second cycle after accept.
      issue(1'b1, 7'd5, 32'hA1B2C3D4, 4'hF);
      drain();
      issue(1'b0, 7'd5, 32'h0, 4'h0);
      check("lat_cycle1_rvalid", {31'd0, bus.rvalid}, 32'd0);
      @(posedge clk);
      #1;
      check("lat_cycle2_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("lat_cycle2_rdata", bus.rdata, 32'hA1B2C3D4);
      drain();

      // Partial byte-enable merge, then a strobe-less write that must not change the word.
      issue(1'b1, 7'd3, 32'h11223344, 4'hF);
      issue(1'b1, 7'd3, 32'hFFFFFFFF, 4'h5);
      issue(1'b0, 7'd3, 32'h0, 4'h0);
      issue(1'b1, 7'd3, 32'hDEADBEEF, 4'h0);
      issue(1'b0, 7'd3, 32'h0, 4'h0);
      issue(1'b1, 7'd3, 32'h00AB00CD, 4'hA);
      issue(1'b0, 7'd3, 32'h0, 4'h0);
      drain();

      // Backpressure: only QDEP requests fit, then aready drops.
      bus.rready = 1'b0;
      bus.avalid = 1'b1;
      bus.awren  = 1'b0;
      bus.aaddr  = 7'd3;
      accepted   = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.aready) begin
            sb.push_back(model[bus.aaddr]);
            accepted++;
            @(posedge clk);
            #1;
            bus.aaddr = bus.aaddr + 7'd2;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      bus.avalid = 1'b0;
      check("bp_accepted", 32'(accepted), 32'(QDEP));
      check("bp_aready_low", {31'd0, bus.aready}, 32'd0);
      check("bp_rvalid", {31'd0, bus.rvalid}, 32'd1);
      bus.rready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_aready_back", {31'd0, bus.aready}, 32'd1);
      drain();

      // Fill the whole array, then stream reads at full rate across queue wrap.
      for (int a = 0; a < 128; a++) begin
         issue(1'b1, 7'(a), $urandom, 4'hF);
      end
      drain();
      resp_count = 0;
      t0 = cyc;
      for (int a = 0; a < 128; a++) begin
         issue(1'b0, 7'(a), 32'h0, 4'h0);
      end
      check("stream_issue_cycles", 32'(cyc - t0), 32'd128);
      drain();
      check("stream_resp_count", 32'(resp_count), 32'd128);
      check("stream_no_bubbles", 32'(last_cyc - first_cyc), 32'd127);

      // Reset with a full queue discards responses but keeps memory contents.
      bus.rready = 1'b0;
      issue(1'b0, 7'd10, 32'h0, 4'h0);
      issue(1'b0, 7'd11, 32'h0, 4'h0);
      issue(1'b0, 7'd12, 32'h0, 4'h0);
      @(posedge clk);
      #2;
      check("prereset_rvalid", {31'd0, bus.rvalid}, 32'd1);
      rstx = 1'b0;
      #1;
      check("midreset_rvalid", {31'd0, bus.rvalid}, 32'd0);
      check("midreset_rdata", bus.rdata, 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rstx = 1'b1;
      #1;
      check("release_aready", {31'd0, bus.aready}, 32'd1);
      check("release_rvalid", {31'd0, bus.rvalid}, 32'd0);
      bus.rready = 1'b1;
      @(posedge clk);
      #1;
      issue(1'b0, 7'd11, 32'h0, 4'h0);
      drain();

      // Writes only produce responses when the write-response option is built in.
      resp_count = 0;
      issue(1'b1, 7'd60, 32'h01020304, 4'hF);
      issue(1'b1, 7'd61, 32'h05060708, 4'hF);
      issue(1'b1, 7'd62, 32'h090A0B0C, 4'hF);
      issue(1'b1, 7'd63, 32'h0D0E0F10, 4'hF);
      issue(1'b0, 7'd61, 32'h0, 4'h0);
      drain();
      repeat (4) @(posedge clk);
      #1;
      exp_resp = WR_RESP ? 5 : 1;
      check("write_resp_count", 32'(resp_count), 32'(exp_resp));
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
